// File: rtl/uart_port_pkg.sv
// Shared definitions for the UART port: data width, register map, status bit
// positions and FSM state encodings.
package uart_port_pkg;

  localparam int UartDataLengh = 8;
  localparam int UartDataWidth = UartDataLengh;

  localparam logic [1:0] UART_ADDR_DATA = 2'b00;
  localparam logic [1:0] UART_ADDR_STAT = 2'b01;

  localparam int STAT_TX_BUSY  = 0;
  localparam int STAT_RX_VALID = 1;
  localparam int STAT_RX_FULL  = 2;
  localparam int STAT_OVR      = 3;
  localparam int STAT_FERR     = 4;

  localparam int RX_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// 4-entry receive FIFO for uart_port; only built when UART_RX_FIFO_EN is
// defined. A push on a full FIFO is accepted only when a pop happens that cycle.
`ifdef UART_RX_FIFO_EN
module uart_rx_fifo
  import uart_port_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [UartDataLengh-1:0] din,
  output logic [UartDataLengh-1:0] dout,
  output logic                     empty,
  output logic                     full
);

  logic [UartDataLengh-1:0] mem [RX_FIFO_DEPTH];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;
  logic       do_push;
  logic       do_pop;

  assign empty   = (count == 3'd0);
  assign full    = (count == 3'(RX_FIFO_DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 2'd1;
      if (do_pop)  rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b0, do_push} - {2'b0, do_pop};
    end
  end

  // When full, wr_ptr aliases the head being popped, so the new byte lands last.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule
`endif

// File: rtl/uart_port.sv
// 8N1 UART port on the CPU UART bus: TX serialiser, RX deserialiser with glitch
// reject, status/data readback. UART_RX_FIFO_EN selects a 4-entry RX FIFO.
module uart_port
  import uart_port_pkg::*;
#(
  parameter int CLK_DIV = 434
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     uart_rd,
  input  logic                     uart_wr,
  input  logic [1:0]               uart_addr,
  input  logic [UartDataLengh-1:0] uart_din,
  output logic [7:0]               uart_dout,
  output logic [7:0]               uart_dout1,
  output logic                     txd,
  input  logic                     rxd
);

  localparam logic [15:0] BIT_LAST  = 16'(CLK_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLK_DIV / 2 - 1);

  tx_state_t                tx_state;
  logic [15:0]              tx_cnt;
  logic [2:0]               tx_bit;
  logic [UartDataLengh-1:0] tx_shift;
  logic                     tx_busy;
  logic                     tx_load;

  assign tx_busy = (tx_state != TX_IDLE);
  assign tx_load = uart_wr && (uart_addr == UART_ADDR_DATA) && !tx_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      txd      <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_load) begin
            tx_state <= TX_START;
            tx_cnt   <= BIT_LAST;
            txd      <= 1'b0;
          end
        end
        TX_START: begin
          if (tx_cnt == 16'd0) begin
            tx_state <= TX_DATA;
            tx_cnt   <= BIT_LAST;
            tx_bit   <= '0;
            txd      <= tx_shift[0];
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == 16'd0) begin
            tx_cnt <= BIT_LAST;
            if (tx_bit == 3'd7) begin
              tx_state <= TX_STOP;
              txd      <= 1'b1;
            end else begin
              tx_bit <= tx_bit + 3'd1;
              txd    <= tx_shift[tx_bit + 3'd1];
            end
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == 16'd0) tx_state <= TX_IDLE;
          else                 tx_cnt   <= tx_cnt - 16'd1;
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (tx_load) tx_shift <= uart_din;
  end

  // RX: two-flop synchroniser, then a half-bit start check and centre sampling.
  logic                     rx_s0;
  logic                     rx_s1;
  rx_state_t                rx_state;
  logic [15:0]              rx_cnt;
  logic [2:0]               rx_bit;
  logic [UartDataLengh-1:0] rx_shift;
  logic                     rx_stop_smp;
  logic                     rx_push;
  logic                     ferr_evt;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s0 <= 1'b1;
      rx_s1 <= 1'b1;
    end else begin
      rx_s0 <= rxd;
      rx_s1 <= rx_s0;
    end
  end

  assign rx_stop_smp = (rx_state == RX_STOP) && (rx_cnt == 16'd0);
  assign rx_push     = rx_stop_smp && rx_s1;
  assign ferr_evt    = rx_stop_smp && !rx_s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (!rx_s1) begin
            rx_state <= RX_START;
            rx_cnt   <= HALF_LAST;
          end
        end
        RX_START: begin
          if (rx_cnt == 16'd0) begin
            if (rx_s1) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_state <= RX_DATA;
              rx_cnt   <= BIT_LAST;
              rx_bit   <= '0;
            end
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == 16'd0) begin
            rx_cnt <= BIT_LAST;
            rx_bit <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == 16'd0) rx_state <= RX_IDLE;
          else                 rx_cnt   <= rx_cnt - 16'd1;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rx_state == RX_DATA && rx_cnt == 16'd0) rx_shift <= {rx_s1, rx_shift[7:1]};
  end

  // Receive buffer: FIFO or single holding register, same empty/full view.
  logic                     pop_req;
  logic                     buf_empty;
  logic                     buf_full;
  logic [UartDataLengh-1:0] buf_dout;
  logic                     ovr_evt;

  assign pop_req = uart_rd && (uart_addr == UART_ADDR_DATA);
  assign ovr_evt = rx_push && buf_full && !pop_req;

`ifdef UART_RX_FIFO_EN
  uart_rx_fifo u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (pop_req),
    .din   (rx_shift),
    .dout  (buf_dout),
    .empty (buf_empty),
    .full  (buf_full)
  );
`else
  logic                     hold_vld;
  logic [UartDataLengh-1:0] hold_data;
  logic                     hold_wr;

  assign hold_wr = rx_push && (!hold_vld || pop_req);

  always_ff @(posedge clk) begin
    if (rst)          hold_vld <= 1'b0;
    else if (hold_wr) hold_vld <= 1'b1;
    else if (pop_req) hold_vld <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (hold_wr) hold_data <= rx_shift;
  end

  assign buf_empty = !hold_vld;
  assign buf_full  = hold_vld;
  assign buf_dout  = hold_vld ? hold_data : '0;
`endif

  // Sticky error flags: a set event outranks a clearing status read.
  logic ferr;
  logic ovr;
  logic stat_clr;

  assign stat_clr = uart_rd && (uart_addr == UART_ADDR_STAT);

  always_ff @(posedge clk) begin
    if (rst) begin
      ferr <= 1'b0;
      ovr  <= 1'b0;
    end else begin
      ferr <= ferr_evt || (ferr && !stat_clr);
      ovr  <= ovr_evt  || (ovr  && !stat_clr);
    end
  end

  always_comb begin
    uart_dout                = '0;
    uart_dout[STAT_TX_BUSY]  = tx_busy;
    uart_dout[STAT_RX_VALID] = !buf_empty;
    uart_dout[STAT_RX_FULL]  = buf_full;
    uart_dout[STAT_OVR]      = ovr;
    uart_dout[STAT_FERR]     = ferr;
  end

  assign uart_dout1 = buf_dout;

endmodule

// File: tb/tb_uart_port.sv
// Directed self-checking bench for uart_port at CLK_DIV=4; expectations adapt
// to the RX buffer depth selected by UART_RX_FIFO_EN.
module tb_uart_port;

  localparam int CLK_DIV = 4;
`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif
  localparam logic [7:0] VALID_ST = (DEPTH == 1) ? 8'h06 : 8'h02;
  localparam logic [9:0] SEQ_A5   = 10'b1101001010;
  localparam logic [9:0] SEQ_3C   = 10'b1001111000;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_rd;
  logic       uart_wr;
  logic [1:0] uart_addr;
  logic [7:0] uart_din;
  logic [7:0] uart_dout;
  logic [7:0] uart_dout1;
  logic       txd;
  logic       rxd;

  int n_chk = 0;
  int n_err = 0;

  uart_port #(.CLK_DIV(CLK_DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .uart_rd    (uart_rd),
    .uart_wr    (uart_wr),
    .uart_addr  (uart_addr),
    .uart_din   (uart_din),
    .uart_dout  (uart_dout),
    .uart_dout1 (uart_dout1),
    .txd        (txd),
    .rxd        (rxd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] addr,
                        input logic [7:0] exp_st, input logic [7:0] exp_dat);
    uart_rd   = 1'b1;
    uart_addr = addr;
    check({tag, "_st"}, uart_dout, exp_st);
    check({tag, "_dat"}, uart_dout1, exp_dat);
    tick(1);
    uart_rd   = 1'b0;
    uart_addr = 2'b00;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    tick(CLK_DIV);
    for (int k = 0; k < 8; k++) begin
      rxd = b[k];
      tick(CLK_DIV);
    end
    rxd = stop;
    tick(CLK_DIV);
    rxd = 1'b1;
  endtask

  task automatic tx_frame(input string tag, input logic [7:0] d,
                          input logic [9:0] seq, input bit inject);
    uart_wr   = 1'b1;
    uart_addr = 2'b00;
    uart_din  = d;
    tick(1);
    uart_wr = 1'b0;
    for (int i = 0; i < 10 * CLK_DIV; i++) begin
      check({tag, "_txd"}, txd, seq[i / CLK_DIV]);
      check({tag, "_busy"}, uart_dout[0], 1'b1);
      uart_wr  = inject && (i == 10);
      uart_din = 8'h3C;
      tick(1);
    end
    uart_wr = 1'b0;
    check({tag, "_done_busy"}, uart_dout[0], 1'b0);
    check({tag, "_done_txd"}, txd, 1'b1);
    tick(2 * CLK_DIV);
    check({tag, "_idle_txd"}, txd, 1'b1);
    check({tag, "_idle_busy"}, uart_dout[0], 1'b0);
  endtask

  initial begin
    rst       = 1'b1;
    uart_rd   = 1'b0;
    uart_wr   = 1'b0;
    uart_addr = 2'b00;
    uart_din  = 8'h00;
    rxd       = 1'b1;
    tick(3);
    rst = 1'b0;
    check("rst_txd", txd, 1'b1);
    check("rst_stat", uart_dout, 8'h00);
    check("rst_data", uart_dout1, 8'h00);
    tick(5);
    check("hold_txd", txd, 1'b1);
    check("hold_stat", uart_dout, 8'h00);
    check("hold_data", uart_dout1, 8'h00);

    // Transmit 0xA5 with a discarded write of 0x3C mid-frame.
    tx_frame("tx_a5", 8'hA5, SEQ_A5, 1'b1);

    // Receive 0x5A, check rx_valid timing, reserved read, pop, pop on empty.
    send_byte(8'h5A, 1'b1);
    check("rx_early", uart_dout[1], 1'b0);
    tick(1);
    check("rx_rise", uart_dout[1], 1'b1);
    check("rx_data", uart_dout1, 8'h5A);
    check("rx_stat", uart_dout, VALID_ST);
    rd_chk("rsvd_rd", 2'b11, VALID_ST, 8'h5A);
    check("rsvd_keep", uart_dout1, 8'h5A);
    uart_wr   = 1'b1;
    uart_addr = 2'b10;
    uart_din  = 8'hFF;
    tick(1);
    uart_wr   = 1'b0;
    uart_addr = 2'b00;
    check("rsvd_wr_txd", txd, 1'b1);
    check("rsvd_wr_stat", uart_dout, VALID_ST);
    rd_chk("pop", 2'b00, VALID_ST, 8'h5A);
    check("pop_after_st", uart_dout, 8'h00);
    check("pop_after_dat", uart_dout1, 8'h00);
    rd_chk("pop_empty", 2'b00, 8'h00, 8'h00);
    check("pop_empty_after", uart_dout, 8'h00);
    tick(4);

    // Overrun: one byte more than the buffer holds.
    for (int i = 0; i <= DEPTH; i++) begin
      send_byte(8'(i + 1), 1'b1);
      tick(4);
    end
    check("ovr_stat", uart_dout, 8'h0E);
    for (int i = 0; i < DEPTH; i++) begin
      rd_chk("ovr_pop", 2'b00, (i == 0) ? 8'h0E : 8'h0A, 8'(i + 1));
    end
    check("ovr_empty_st", uart_dout, 8'h08);
    rd_chk("ovr_clr", 2'b01, 8'h08, 8'h00);
    check("ovr_cleared", uart_dout, 8'h00);

    // Push and pop in the same cycle on a full buffer.
    for (int i = 0; i < DEPTH; i++) begin
      send_byte(8'h10 + 8'(i), 1'b1);
      tick(4);
    end
    send_byte(8'h20, 1'b1);
    rd_chk("pp_pop", 2'b00, 8'h06, 8'h10);
    check("pp_stat", uart_dout, 8'h06);
    for (int i = 0; i < DEPTH; i++) begin
      rd_chk("pp_drain", 2'b00, (i == 0) ? 8'h06 : 8'h02,
             (i < DEPTH - 1) ? 8'h11 + 8'(i) : 8'h20);
    end
    check("pp_empty", uart_dout, 8'h00);

    // Framing error, with the clearing read racing the error event.
    send_byte(8'h33, 1'b1);
    tick(4);
    send_byte(8'h77, 1'b0);
    rd_chk("ferr_race", 2'b01, VALID_ST, 8'h33);
    check("ferr_wins", uart_dout, VALID_ST | 8'h10);
    tick(8);
    check("ferr_keep_st", uart_dout, VALID_ST | 8'h10);
    check("ferr_keep_dat", uart_dout1, 8'h33);
    rd_chk("ferr_clr", 2'b01, VALID_ST | 8'h10, 8'h33);
    check("ferr_cleared", uart_dout, VALID_ST);
    rd_chk("ferr_pop", 2'b00, VALID_ST, 8'h33);
    check("ferr_empty", uart_dout, 8'h00);

    // One-cycle low glitch is rejected.
    rxd = 1'b0;
    tick(1);
    rxd = 1'b1;
    tick(12);
    check("glitch_st", uart_dout, 8'h00);
    check("glitch_dat", uart_dout1, 8'h00);

    // Reset during TX bit 3 with a byte waiting in the RX buffer.
    send_byte(8'h42, 1'b1);
    tick(4);
    check("pre_rst_dat", uart_dout1, 8'h42);
    uart_wr   = 1'b1;
    uart_addr = 2'b00;
    uart_din  = 8'hA5;
    tick(1);
    uart_wr = 1'b0;
    tick(4 * CLK_DIV + 2);
    check("tx_bit3", txd, 1'b0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rst_mid_txd", txd, 1'b1);
    check("rst_mid_st", uart_dout, 8'h00);
    check("rst_mid_dat", uart_dout1, 8'h00);
    tx_frame("tx_3c", 8'h3C, SEQ_3C, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
